shot_sequencer: RTL and testbench
=================================

SHOT_SEQUENCER -- requirements
Module: shot_sequencer

Interface
REQ-001 Parameter HOOP_X_MIN, default 10'd560, leftmost ball_x counted as inside the hoop.
REQ-002 Parameter HOOP_X_MAX, default 10'd600, rightmost ball_x counted as inside the hoop.
REQ-003 Parameter HOOP_Y, default 10'd160, hoop rim row; screen y grows downward.
REQ-004 Parameter FLOOR_Y, default 10'd470, ball_y at or beyond which a shot is a miss.
REQ-005 Parameter X_LIMIT, default 10'd639, ball_x at or beyond which a shot is a miss.
REQ-006 Parameter SETTLE_CYCLES, default 24'd5_000_000, length of the post-shot hold in clocks.
REQ-007 CLK100MHZ  in  1  sole clock; all logic on its rising edge.
REQ-008 rst  in  1  reset; synchronous and active-high.
REQ-009 btn_shoot  in  1  shoot request, level, already synchronized; only a rising edge is acted on.
REQ-010 shot_zero  in  1  shot-clock-expired level.
REQ-011 ball_x  in  10  current ball column.
REQ-012 ball_y  in  10  current ball row.
REQ-013 kin_rst  out  1  reset to the kinematic block.
REQ-014 launch  out  1  one-cycle pulse that starts a shot.
REQ-015 clk_restart  out  1  one-cycle pulse that reloads the shot clock.
REQ-016 result_valid  out  1  one-cycle pulse when a shot is resolved.
REQ-017 result_made  out  1  qualifies result_valid: 1 = made, 0 = miss; held until the next result.
REQ-018 attempts  out  8  shots launched since reset.
REQ-019 makes  out  8  shots made since reset.
REQ-020 state  out  3  encoded FSM state: IDLE=0, FLIGHT=1, SCORE=2, MISS=3, SETTLE=4.

Function
REQ-021 All outputs SHALL be registered.
REQ-022 A shoot edge SHALL be btn_shoot=1 while its registered previous value is 0.
REQ-023 IDLE: on a shoot edge, go to FLIGHT next cycle, pulse launch, and increment attempts (saturating at 255).
REQ-024 IDLE: shot_zero and ball motion SHALL be ignored.
REQ-025 On entry to FLIGHT, y_prev SHALL be loaded with ball_y; in FLIGHT, y_prev SHALL update every cycle.
REQ-026 FLIGHT make condition: y_prev < HOOP_Y, ball_y >= HOOP_Y, and HOOP_X_MIN <= ball_x <= HOOP_X_MAX (inclusive); on make, go to SCORE.
REQ-027 FLIGHT miss condition: ball_y >= FLOOR_Y, or ball_x >= X_LIMIT, or shot_zero=1; on miss, go to MISS.
REQ-028 If the make and miss conditions hold in the same cycle, make SHALL win.
REQ-029 Shoot edges in FLIGHT, SCORE, MISS and SETTLE SHALL be ignored and SHALL NOT be queued.
REQ-030 SCORE lasts 1 cycle: pulse result_valid, set result_made=1, increment makes (saturating at 255), then go to SETTLE.
REQ-031 MISS lasts 1 cycle: pulse result_valid, set result_made=0, then go to SETTLE.
REQ-032 SETTLE: kin_rst=1 and the settle counter runs from 0; at count SETTLE_CYCLES-1, pulse clk_restart, clear the counter and go to IDLE.
REQ-033 kin_rst SHALL be 0 in IDLE, FLIGHT, SCORE and MISS.
REQ-034 makes SHALL never exceed attempts.
REQ-035 Illegal state encodings SHALL go to SETTLE with the counter cleared.

Reset
REQ-036 While rst=1: state=IDLE, kin_rst=1, launch=0, clk_restart=0, result_valid=0, result_made=0, attempts=0, makes=0, settle counter=0.
REQ-037 While rst=1, the previous-button register SHALL load btn_shoot, so a button held through reset does not launch.
REQ-038 In the first cycle after rst falls, kin_rst=0.
REQ-039 rst asserted in any state, including mid-FLIGHT or mid-SETTLE, SHALL abort with no result_valid and no clk_restart.

Verification
REQ-040 Make: after rst, btn_shoot 0->1; ball_y steps 150 -> 165 at ball_x=580 -> launch pulse, attempts=1, then result_valid with result_made=1, makes=1, state sequence 1,2,4.
REQ-041 Miss (off-target and floor): ball_y crosses 160 at ball_x=500, then reaches 470 -> result_made=0, makes=0, attempts=1.
REQ-042 Settle timing: with SETTLE_CYCLES=8 -> kin_rst high for exactly 8 cycles, clk_restart pulses on the 8th cycle, state=0 next cycle.
REQ-043 Priority and clock expiry: a hoop crossing coincident with shot_zero=1 -> make; shot_zero=1 alone in FLIGHT -> miss; shot_zero=1 in IDLE -> no state change.
REQ-044 Edge handling: btn_shoot held high across rst and through a full shot -> no launch until the button is released and pressed again; presses during FLIGHT or SETTLE are ignored.
REQ-045 Saturation and reset abort: 256 launches -> attempts stays 255; rst mid-FLIGHT -> all counters 0, no result_valid.

Source files
------------

// File: rtl/shot_sequencer.sv
// -----------------------------------------------------------------------------
// shot_sequencer
//
// Sequences a single basketball shot: waits for a shoot press, launches the
// ball, watches the ball position until the shot is a make (ball drops through
// the rim row inside the hoop span) or a miss (floor, right edge, or shot
// clock expiry), reports the result, then holds the kinematic block in reset
// for a settle period before reloading the shot clock and returning to idle.
//
// Ports
//   CLK100MHZ     in   1   sole clock, rising edge
//   rst           in   1   synchronous active-high reset
//   btn_shoot     in   1   shoot request level (synchronized); rising edge acts
//   shot_zero     in   1   shot clock expired
//   ball_x        in  10   current ball column
//   ball_y        in  10   current ball row (grows downward)
//   kin_rst       out  1   reset to the kinematic block (high in SETTLE/reset)
//   launch        out  1   one-cycle pulse starting a shot
//   clk_restart   out  1   one-cycle pulse reloading the shot clock
//   result_valid  out  1   one-cycle pulse when a shot is resolved
//   result_made   out  1   1 = made, 0 = miss; held until the next result
//   attempts      out  8   shots launched since reset (saturating)
//   makes         out  8   shots made since reset (saturating)
//   state         out  3   IDLE=0 FLIGHT=1 SCORE=2 MISS=3 SETTLE=4
//
// Every output is driven straight from a register. The FSM next-state logic
// also computes the next value of each output, so pulses coincide with the
// state they belong to (launch with the first FLIGHT cycle, result_valid with
// SCORE/MISS, clk_restart with the last SETTLE cycle).
// -----------------------------------------------------------------------------
module shot_sequencer #(
   parameter logic [9:0]  HOOP_X_MIN    = 10'd560,
   parameter logic [9:0]  HOOP_X_MAX    = 10'd600,
   parameter logic [9:0]  HOOP_Y        = 10'd160,
   parameter logic [9:0]  FLOOR_Y       = 10'd470,
   parameter logic [9:0]  X_LIMIT       = 10'd639,
   parameter logic [23:0] SETTLE_CYCLES = 24'd5_000_000
) (
   input  logic       CLK100MHZ,
   input  logic       rst,
   input  logic       btn_shoot,
   input  logic       shot_zero,
   input  logic [9:0] ball_x,
   input  logic [9:0] ball_y,
   output logic       kin_rst,
   output logic       launch,
   output logic       clk_restart,
   output logic       result_valid,
   output logic       result_made,
   output logic [7:0] attempts,
   output logic [7:0] makes,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FLIGHT = 3'd1,
      ST_SCORE  = 3'd2,
      ST_MISS   = 3'd3,
      ST_SETTLE = 3'd4
   } state_t;

   // Terminal value of the settle counter.
   localparam logic [23:0] SETTLE_LAST = SETTLE_CYCLES - 24'd1;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_t      r_state;
   logic [23:0] r_settle_cnt;
   logic [9:0]  r_y_prev;
   logic        r_btn_prev;
   logic        r_kin_rst;
   logic        r_launch;
   logic        r_clk_restart;
   logic        r_result_valid;
   logic        r_result_made;
   logic [7:0]  r_attempts;
   logic [7:0]  r_makes;

   // ------------------------------------------------------------------
   // Combinational next values
   // ------------------------------------------------------------------
   state_t      w_state_next;
   logic [23:0] w_settle_cnt_next;
   logic        w_launch_next;
   logic        w_clk_restart_next;
   logic        w_result_valid_next;
   logic        w_result_made_next;
   logic        w_kin_rst_next;
   logic [7:0]  w_attempts_next;
   logic [7:0]  w_makes_next;

   logic        w_shoot_edge;
   logic        w_in_hoop_x;
   logic        w_make;
   logic        w_miss;

   assign w_shoot_edge = btn_shoot & ~r_btn_prev;

   assign w_in_hoop_x = (ball_x >= HOOP_X_MIN) && (ball_x <= HOOP_X_MAX);

   // A make is a downward crossing of the rim row: last cycle above it,
   // this cycle at or below it, while inside the hoop span.
   assign w_make = (r_y_prev < HOOP_Y) && (ball_y >= HOOP_Y) && w_in_hoop_x;

   assign w_miss = (ball_y >= FLOOR_Y) || (ball_x >= X_LIMIT) || shot_zero;

   // ------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next        = r_state;
      w_settle_cnt_next   = r_settle_cnt;
      w_launch_next       = 1'b0;
      w_result_valid_next = 1'b0;
      w_result_made_next  = r_result_made;
      w_attempts_next     = r_attempts;
      w_makes_next        = r_makes;

      case (r_state)
         ST_IDLE: begin
            // Ball motion and shot clock are irrelevant until a shot starts.
            if (w_shoot_edge) begin
               w_state_next  = ST_FLIGHT;
               w_launch_next = 1'b1;
               if (r_attempts != 8'hFF) begin
                  w_attempts_next = r_attempts + 8'd1;
               end
            end
         end

         ST_FLIGHT: begin
            // Make is checked first so a coincident miss condition loses.
            if (w_make) begin
               w_state_next        = ST_SCORE;
               w_result_valid_next = 1'b1;
               w_result_made_next  = 1'b1;
               // Bounded by attempts as well as by 255, so the make count
               // can never overtake the launch count.
               if ((r_makes != 8'hFF) && (r_makes < r_attempts)) begin
                  w_makes_next = r_makes + 8'd1;
               end
            end else if (w_miss) begin
               w_state_next        = ST_MISS;
               w_result_valid_next = 1'b1;
               w_result_made_next  = 1'b0;
            end
         end

         ST_SCORE, ST_MISS: begin
            w_state_next      = ST_SETTLE;
            w_settle_cnt_next = 24'd0;
         end

         ST_SETTLE: begin
            if (r_settle_cnt >= SETTLE_LAST) begin
               w_state_next      = ST_IDLE;
               w_settle_cnt_next = 24'd0;
            end else begin
               w_settle_cnt_next = r_settle_cnt + 24'd1;
            end
         end

         default: begin
            // Unreachable encodings recover through a full settle period.
            w_state_next      = ST_SETTLE;
            w_settle_cnt_next = 24'd0;
         end
      endcase

      // Registered outputs are computed from the upcoming state so they
      // line up with it: kin_rst covers exactly the SETTLE cycles and
      // clk_restart marks the final SETTLE cycle.
      w_kin_rst_next     = (w_state_next == ST_SETTLE);
      w_clk_restart_next = (w_state_next == ST_SETTLE) &&
                           (w_settle_cnt_next == SETTLE_LAST);
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge CLK100MHZ) begin
      // The button history is tracked even in reset so that a button held
      // through reset does not count as a fresh press afterwards.
      r_btn_prev <= btn_shoot;

      if (rst) begin
         r_state        <= ST_IDLE;
         r_settle_cnt   <= 24'd0;
         r_y_prev       <= 10'd0;
         r_kin_rst      <= 1'b1;
         r_launch       <= 1'b0;
         r_clk_restart  <= 1'b0;
         r_result_valid <= 1'b0;
         r_result_made  <= 1'b0;
         r_attempts     <= 8'd0;
         r_makes        <= 8'd0;
      end else begin
         r_state        <= w_state_next;
         r_settle_cnt   <= w_settle_cnt_next;
         r_kin_rst      <= w_kin_rst_next;
         r_launch       <= w_launch_next;
         r_clk_restart  <= w_clk_restart_next;
         r_result_valid <= w_result_valid_next;
         r_result_made  <= w_result_made_next;
         r_attempts     <= w_attempts_next;
         r_makes        <= w_makes_next;

         // y_prev is captured on the launch edge and then every FLIGHT
         // cycle, so it always holds the previous cycle's row in FLIGHT.
         if (w_launch_next || (r_state == ST_FLIGHT)) begin
            r_y_prev <= ball_y;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign kin_rst      = r_kin_rst;
   assign launch       = r_launch;
   assign clk_restart  = r_clk_restart;
   assign result_valid = r_result_valid;
   assign result_made  = r_result_made;
   assign attempts     = r_attempts;
   assign makes        = r_makes;
   assign state        = r_state;

endmodule

// File: tb/tb_shot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shot_sequencer
//
// Directed bench for shot_sequencer with a short settle period (8 clocks).
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_shot_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_shoot;
   logic       shot_zero;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic       kin_rst;
   logic       launch;
   logic       clk_restart;
   logic       result_valid;
   logic       result_made;
   logic [7:0] attempts;
   logic [7:0] makes;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shot_sequencer #(
      .SETTLE_CYCLES(24'd8)
   ) dut (
      .CLK100MHZ   (clk),
      .rst         (rst),
      .btn_shoot   (btn_shoot),
      .shot_zero   (shot_zero),
      .ball_x      (ball_x),
      .ball_y      (ball_y),
      .kin_rst     (kin_rst),
      .launch      (launch),
      .clk_restart (clk_restart),
      .result_valid(result_valid),
      .result_made (result_made),
      .attempts    (attempts),
      .makes       (makes),
      .state       (state)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst       = 1'b1;
      btn_shoot = 1'b0;
      shot_zero = 1'b0;
      ball_x    = 10'd100;
      ball_y    = 10'd300;
      tick;
      tick;
      rst = 1'b0;
      tick;
   endtask

   // Rising edge on the button for one cycle; expects the launch pulse.
   task automatic press(input string name);
      btn_shoot = 1'b1;
      tick;
      btn_shoot = 1'b0;
      checks++;
      if ({state, launch} !== {3'd1, 1'b1}) begin
         errors++;
         $display("FAIL %s_launch got state=%0d launch=%0b want state=1 launch=1",
                  name, state, launch);
      end
   endtask

   // Called in the first SETTLE cycle; walks all 8 cycles and the exit.
   // With toggle set, the button is released and pressed again mid-settle.
   task automatic run_settle(input string name, input bit toggle);
      for (int i = 1; i <= 8; i++) begin
         checks++;
         if ({state, kin_rst, clk_restart} !== {3'd4, 1'b1, 1'(i == 8)}) begin
            errors++;
            $display("FAIL %s_settle%0d got state=%0d kin_rst=%0b clk_restart=%0b want 4/1/%0b",
                     name, i, state, kin_rst, clk_restart, (i == 8));
         end
         if (toggle && i == 2) btn_shoot = 1'b0;
         if (toggle && i == 4) btn_shoot = 1'b1;
         tick;
      end
      checks++;
      if ({state, kin_rst, clk_restart, launch} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL %s_settle_exit got state=%0d kin_rst=%0b clk_restart=%0b launch=%0b want 0/0/0/0",
                  name, state, kin_rst, clk_restart, launch);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (state !== 3'd0 && n < 20) begin
         tick;
         n++;
      end
      checks++;
      if (state !== 3'd0) begin
         errors++;
         $display("FAIL %s_idle_timeout got state=%0d want 0", name, state);
      end
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      btn_shoot = 1'b0;
      shot_zero = 1'b0;
      ball_x    = 10'd0;
      ball_y    = 10'd300;
      tick;
      tick;
      checks++;
      if ({state, kin_rst, launch, clk_restart, result_valid, result_made, attempts, makes}
          !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0}) begin
         errors++;
         $display("FAIL reset_values got state=%0d kin_rst=%0b launch=%0b clk_restart=%0b rv=%0b made=%0b att=%0d mk=%0d want 0/1/0/0/0/0/0/0",
                  state, kin_rst, launch, clk_restart, result_valid, result_made, attempts, makes);
      end
      rst = 1'b0;
      tick;
      checks++;
      if ({state, kin_rst} !== {3'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_release got state=%0d kin_rst=%0b want 0/0", state, kin_rst);
      end
      $display("test_reset done");
   endtask

   task automatic test_make;
      ball_x = 10'd580;
      ball_y = 10'd150;
      press("make");
      checks++;
      if (attempts !== 8'd1) begin
         errors++;
         $display("FAIL make_attempts got %0d want 1", attempts);
      end
      ball_y = 10'd165;
      tick;
      checks++;
      if ({state, result_valid, result_made, makes} !== {3'd2, 1'b1, 1'b1, 8'd1}) begin
         errors++;
         $display("FAIL make_score got state=%0d rv=%0b made=%0b mk=%0d want 2/1/1/1",
                  state, result_valid, result_made, makes);
      end
      tick;
      checks++;
      if ({result_valid, result_made} !== {1'b0, 1'b1}) begin
         errors++;
         $display("FAIL make_hold got rv=%0b made=%0b want 0/1", result_valid, result_made);
      end
      run_settle("make", 1'b0);
      $display("test_make done attempts=%0d makes=%0d", attempts, makes);
   endtask

   task automatic test_miss;
      do_reset;
      ball_x = 10'd500;
      ball_y = 10'd150;
      press("miss");
      ball_y = 10'd165;
      tick;
      checks++;
      if ({state, result_valid} !== {3'd1, 1'b0}) begin
         errors++;
         $display("FAIL miss_offtarget got state=%0d rv=%0b want 1/0", state, result_valid);
      end
      ball_y = 10'd470;
      tick;
      checks++;
      if ({state, result_valid, result_made, makes, attempts} !== {3'd3, 1'b1, 1'b0, 8'd0, 8'd1}) begin
         errors++;
         $display("FAIL miss_floor got state=%0d rv=%0b made=%0b mk=%0d att=%0d want 3/1/0/0/1",
                  state, result_valid, result_made, makes, attempts);
      end
      tick;
      run_settle("miss", 1'b0);
      $display("test_miss done");
   endtask

   task automatic test_priority;
      do_reset;
      ball_x = 10'd580;
      ball_y = 10'd150;
      press("prio");
      ball_y    = 10'd165;
      shot_zero = 1'b1;
      tick;
      checks++;
      if ({state, result_valid, result_made} !== {3'd2, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL prio_make_wins got state=%0d rv=%0b made=%0b want 2/1/1",
                  state, result_valid, result_made);
      end
      tick;
      run_settle("prio", 1'b0);
      repeat (3) tick;
      checks++;
      if ({state, attempts} !== {3'd0, 8'd1}) begin
         errors++;
         $display("FAIL prio_idle_shotzero got state=%0d att=%0d want 0/1", state, attempts);
      end
      shot_zero = 1'b0;
      ball_x    = 10'd100;
      ball_y    = 10'd300;
      press("clock");
      shot_zero = 1'b1;
      tick;
      checks++;
      if ({state, result_made, attempts, makes} !== {3'd3, 1'b0, 8'd2, 8'd1}) begin
         errors++;
         $display("FAIL prio_clock_miss got state=%0d made=%0b att=%0d mk=%0d want 3/0/2/1",
                  state, result_made, attempts, makes);
      end
      shot_zero = 1'b0;
      wait_idle("prio");
      $display("test_priority done");
   endtask

   task automatic test_bounds;
      logic [9:0] xs [7]  = '{10'd560, 10'd600, 10'd559, 10'd601, 10'd580, 10'd639, 10'd638};
      logic [9:0] y0s [7] = '{10'd150, 10'd150, 10'd150, 10'd150, 10'd160, 10'd300, 10'd300};
      logic [9:0] y1s [7] = '{10'd160, 10'd165, 10'd165, 10'd165, 10'd165, 10'd300, 10'd469};
      logic [2:0] exp [7] = '{3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd3, 3'd1};
      do_reset;
      for (int k = 0; k < 7; k++) begin
         ball_x = xs[k];
         ball_y = y0s[k];
         press("bounds");
         ball_y = y1s[k];
         tick;
         checks++;
         if (state !== exp[k]) begin
            errors++;
            $display("FAIL bounds%0d x=%0d y=%0d->%0d got state=%0d want %0d",
                     k, xs[k], y0s[k], y1s[k], state, exp[k]);
         end
         shot_zero = 1'b1;
         wait_idle("bounds");
         shot_zero = 1'b0;
         $display("bounds case %0d x=%0d y=%0d->%0d state=%0d", k, xs[k], y0s[k], y1s[k], exp[k]);
      end
   endtask

   task automatic test_edge;
      rst       = 1'b1;
      btn_shoot = 1'b1;
      shot_zero = 1'b0;
      ball_x    = 10'd580;
      ball_y    = 10'd150;
      tick;
      tick;
      rst = 1'b0;
      tick;
      tick;
      checks++;
      if ({state, launch, attempts} !== {3'd0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL edge_held_reset got state=%0d launch=%0b att=%0d want 0/0/0",
                  state, launch, attempts);
      end
      btn_shoot = 1'b0;
      tick;
      btn_shoot = 1'b1;
      tick;
      checks++;
      if ({state, launch, attempts} !== {3'd1, 1'b1, 8'd1}) begin
         errors++;
         $display("FAIL edge_first_press got state=%0d launch=%0b att=%0d want 1/1/1",
                  state, launch, attempts);
      end
      btn_shoot = 1'b0;
      tick;
      btn_shoot = 1'b1;
      tick;
      checks++;
      if ({state, launch, attempts} !== {3'd1, 1'b0, 8'd1}) begin
         errors++;
         $display("FAIL edge_press_in_flight got state=%0d launch=%0b att=%0d want 1/0/1",
                  state, launch, attempts);
      end
      ball_y = 10'd165;
      tick;
      tick;
      run_settle("edge", 1'b1);
      repeat (2) tick;
      checks++;
      if ({state, launch, attempts} !== {3'd0, 1'b0, 8'd1}) begin
         errors++;
         $display("FAIL edge_no_queue got state=%0d launch=%0b att=%0d want 0/0/1",
                  state, launch, attempts);
      end
      btn_shoot = 1'b0;
      tick;
      ball_x = 10'd100;
      ball_y = 10'd300;
      press("edge_repress");
      checks++;
      if (attempts !== 8'd2) begin
         errors++;
         $display("FAIL edge_repress_attempts got %0d want 2", attempts);
      end
      shot_zero = 1'b1;
      wait_idle("edge");
      shot_zero = 1'b0;
      $display("test_edge done");
   endtask

   task automatic test_saturation;
      do_reset;
      for (int n = 1; n <= 256; n++) begin
         press("sat");
         shot_zero = 1'b1;
         tick;
         shot_zero = 1'b0;
         repeat (9) tick;
         if (n >= 254) begin
            checks++;
            if ({state, attempts} !== {3'd0, ((n >= 255) ? 8'd255 : 8'(n))}) begin
               errors++;
               $display("FAIL sat_shot%0d got state=%0d att=%0d", n, state, attempts);
            end
         end
      end
      ball_x = 10'd580;
      ball_y = 10'd150;
      press("sat_make");
      ball_y = 10'd165;
      tick;
      checks++;
      if ({attempts, makes} !== {8'd255, 8'd1}) begin
         errors++;
         $display("FAIL sat_make got att=%0d mk=%0d want 255/1", attempts, makes);
      end
      wait_idle("sat");
      $display("test_saturation done attempts=%0d", attempts);
   endtask

   task automatic test_abort;
      bit seen;
      do_reset;
      ball_x = 10'd100;
      ball_y = 10'd300;
      press("abort_flight");
      tick;
      rst = 1'b1;
      tick;
      checks++;
      if ({state, kin_rst, result_valid, clk_restart, attempts, makes}
          !== {3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
         errors++;
         $display("FAIL abort_flight got state=%0d kin_rst=%0b rv=%0b cr=%0b att=%0d mk=%0d want 0/1/0/0/0/0",
                  state, kin_rst, result_valid, clk_restart, attempts, makes);
      end
      rst = 1'b0;
      tick;
      ball_x = 10'd580;
      ball_y = 10'd150;
      press("abort_settle");
      ball_y = 10'd165;
      tick;
      tick;
      tick;
      tick;
      rst  = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         tick;
         if (clk_restart || result_valid) seen = 1'b1;
      end
      checks++;
      if ({seen, state, attempts, makes} !== {1'b0, 3'd0, 8'd0, 8'd0}) begin
         errors++;
         $display("FAIL abort_settle got pulses=%0b state=%0d att=%0d mk=%0d want 0/0/0/0",
                  seen, state, attempts, makes);
      end
      rst = 1'b0;
      tick;
      $display("test_abort done");
   endtask

   initial begin
      test_reset;
      test_make;
      test_miss;
      test_priority;
      test_bounds;
      test_edge;
      test_saturation;
      test_abort;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
